if_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage: generates sequential PCs, issues requests to

---
 rtl/if_pkg.sv | 8 +
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_fifo.sv | 69 ++++++
 rtl/if_fetch_unit.sv | 81 ++++++++
 tb/tb_if_fetch_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch slice: default widths, PC step, alignment and reset PC.
package if_pkg;
    localparam int          PC_W_DEF     = 32;
    localparam int          INSTR_W_DEF  = 32;
    localparam int          PC_STEP      = 4;
    localparam int          ALIGN_BITS   = 2;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: redirect input, imem request/response channel and the decode-facing output channel.
interface if_fetch_unit_if import if_pkg::*; #(
    parameter int WIDTH   = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               redirect_valid;
    logic [WIDTH-1:0]   redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [WIDTH-1:0]   imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/if_fetch_fifo.sv
// In-order {pc,instr} queue, head word visible combinationally; push lands one cycle later.
// Flush beats push/pop; when full, a same-cycle pop frees the slot for the push.
module if_fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter int  DW    = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_dat,
    output logic [CW-1:0] count,
    output logic          empty
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty && !flush;
    assign do_push  = push && !flush && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    // The upstream credit scheme must never offer a push into a full, non-draining queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && (count_q == CW'(DEPTH)) && !do_pop));
endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: sequential PCs, credit-limited imem requests, {pc,instr} to decode 1 cycle after a response.
// Backpressure: out_ready low fills the queue; requests stop once queued + in-flight reaches DEPTH.
module if_fetch_unit import if_pkg::*; #(
    parameter int               WIDTH    = PC_W_DEF,
    parameter int               INSTR_W  = INSTR_W_DEF,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
    input  logic           clk,
    input  logic           rst,
    if_fetch_unit_if.master bus
);
    localparam int               CW         = $clog2(DEPTH + 1);
    localparam int               CW1        = CW + 1;
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'((1 << ALIGN_BITS) - 1);

    logic [WIDTH-1:0]         fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0]         rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic [CW-1:0]            drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]            q_count;
    logic                     q_empty;
    logic [WIDTH+INSTR_W-1:0] q_head;
    logic                     credit_ok, req_fire, rsp_keep, out_fire;

    assign credit_ok          = ({1'b0, q_count} + {1'b0, inflight_q}) < CW1'(DEPTH);
    assign bus.imem_req_valid = rst && !bus.redirect_valid && credit_ok;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep           = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
    assign bus.out_valid      = rst && !q_empty && !bus.redirect_valid;
    assign out_fire           = bus.out_valid && bus.out_ready;
    assign {bus.out_pc, bus.out_instr} = q_head;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ALIGN_MASK;
            rsp_pc_d   = bus.redirect_pc & ALIGN_MASK;
            // Every outstanding response, including ones already marked stale, is now stale.
            drop_cnt_d = inflight_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
            if (rsp_keep)                 rsp_pc_d   = rsp_pc_q + STEP;
            else if (bus.imem_rsp_valid)  drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    if_fetch_fifo #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + INSTR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rsp_keep),
        .push_dat ({rsp_pc_q, bus.imem_rsp_data}),
        .pop      (out_fire),
        .flush    (bus.redirect_valid),
        .head_dat (q_head),
        .count    (q_count),
        .empty    (q_empty)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order variable-latency memory model, epoch-tagged scoreboard, directed + random phases.
module tb_if_fetch_unit;
    localparam int          WIDTH    = 32;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    if_fetch_unit_if #(.WIDTH(WIDTH), .INSTR_W(INSTR_W)) bus ();

    if_fetch_unit #(.WIDTH(WIDTH), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          cyc = 0, epoch = 0, lat_min = 1, lat_max = 1, last_due = 0;
    int          n_checks = 0, n_fail = 0, n_pops = 0, n_reqs = 0;
    logic [31:0] model_fetch_pc = RESET_PC;
    logic        want_first = 1'b0;
    logic [31:0] first_target = RESET_PC;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit rsp_due();
        return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: inputs change at negedge, checks at +1/+2, model bookkeeping at +3.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                        input logic ordy, input logic qrdy);
        mreq_t m;
        int    lat, d;
        @(negedge clk);
        rst                = r;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        bus.out_ready      = ordy;
        bus.imem_req_ready = qrdy;
        if (r && rsp_due()) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mdata(mem_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        chk("req_valid", 32'(bus.imem_req_valid),
            32'(r && !rd && ((exp_q.size() + mem_q.size()) < DEPTH)));
        if (r) chk("req_addr", bus.imem_req_addr, model_fetch_pc);
        #2;
        if (!r) begin
            mem_q.delete();
            exp_q.delete();
            model_fetch_pc = RESET_PC;
            epoch++;
            want_first   = 1'b1;
            first_target = RESET_PC;
        end else begin
            if (bus.imem_rsp_valid) begin
                m = mem_q.pop_front();
                if (!rd && m.epoch == epoch)
                    exp_q.push_back('{pc: m.addr, instr: mdata(m.addr)});
            end
            if (bus.imem_req_valid && qrdy) begin
                lat = int'($urandom_range(lat_max, lat_min));
                d   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = d;
                mem_q.push_back('{addr: bus.imem_req_addr, due: d, epoch: epoch});
                n_reqs++;
                model_fetch_pc = model_fetch_pc + 32'd4;
            end
            if (rd) begin
                epoch++;
                exp_q.delete();
                model_fetch_pc = rpc & 32'hFFFF_FFFC;
                want_first     = 1'b1;
                first_target   = model_fetch_pc;
            end
        end
        cyc++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            chk("out_valid", 32'(bus.out_valid), 32'(rst && !bus.redirect_valid && (exp_q.size() > 0)));
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pops++;
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_instr", bus.out_instr, e.instr);
                if (want_first) begin
                    chk("first_pc_after_restart", bus.out_pc, first_target);
                    want_first = 1'b0;
                end
            end
        end
    end

    initial begin : main
        int          p0, r0;
        bit          done;
        logic        rr, rd;
        logic [31:0] rpc;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.out_ready      = 1'b0;

        // Free-run at latency 1: after the 2-cycle fill, one instruction per cycle.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        p0 = n_pops;
        repeat (30) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t1_no_bubbles", p0 + 28, n_pops);

        // Decode stall: exactly DEPTH requests, head held at PC 0, then drains in order.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        r0 = n_reqs;
        repeat (20) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_req_count", n_reqs - r0, 4);
        chk("t2_head_pc", bus.out_pc, 32'h0);
        chk("t2_out_valid_held", 32'(bus.out_valid), 32'd1);
        p0 = n_pops;
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_drain", n_pops - p0, 12);

        // Latency 3: redirect with two requests in flight; both must be dropped.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 10 && !(mem_q.size() == 2 && !rsp_due()); i++)
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_two_in_flight", mem_q.size(), 2);
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect in the same cycle as a response and a ready decode.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        lat_min = 1;
        lat_max = 1;
        repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (rsp_due() && exp_q.size() > 0) begin
                p0 = n_pops;
                step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
                chk("t4_no_pop_on_redirect", n_pops - p0, 0);
                done = 1'b1;
            end else begin
                step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            end
        end
        chk("t4_redirect_hit_rsp", 32'(done), 32'd1);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Misaligned target and address wrap.
        step(1'b1, 1'b1, 32'h103, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("t5_align", bus.imem_req_addr, 32'h100);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("t5_wrap_start", bus.imem_req_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("t5_wrap_zero", bus.imem_req_addr, 32'h0);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset mid-stream with a full queue.
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_full_count", 32'(dut.q_count), 32'd4);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("t6_addr", bus.imem_req_addr, RESET_PC);
        chk("t6_count", 32'(dut.q_count), 32'd0);
        chk("t6_inflight", 32'(dut.inflight_q), 32'd0);
        chk("t6_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic: variable latency, stalls, redirects, occasional reset.
        lat_min = 1;
        lat_max = 4;
        repeat (3000) begin
            rr  = ($urandom_range(199) != 0);
            rd  = ($urandom_range(99) < 6);
            rpc = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step(rr, rd, rpc, ($urandom_range(99) < 70), ($urandom_range(99) < 75));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
